// File: rtl/eth_hdr_parser.sv
// Receive-side Ethernet header parser: captures the 14-byte MAC header,
// optionally filters on destination address, forwards payload bytes through
// a one-entry registered valid/ready stage, and keeps frame/drop counters.
module eth_hdr_parser #(
  parameter logic [47:0] P_MAC_ADDR  = 48'h3A52023E1800,
  parameter bit          P_FILTER_EN = 1'b1
) (
  input  logic        sys_rx_clk,
  input  logic        sys_rx_rst,
  input  logic [7:0]  in_byte,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        in_sof,
  input  logic        in_eof,
  output logic [47:0] hdr_dst_mac,
  output logic [47:0] hdr_src_mac,
  output logic [15:0] hdr_ethertype,
  output logic        hdr_vld,
  output logic [7:0]  pl_byte,
  output logic        pl_vld,
  input  logic        pl_rdy,
  output logic        pl_sof,
  output logic        pl_eof,
  output logic        pl_abort,
  output logic        runt_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx;
  logic [3:0]  wr_idx;
  logic        pl_first;
  logic        xfer;
  logic        dst_reject;
  logic        hdr_wr, hdr_ok, runt, abort, pl_load;
  logic [1:0]  drop_inc;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // The output register only throttles the input while payload is flowing.
  assign in_rdy = (state == PAYLOAD) ? (~pl_vld | pl_rdy) : 1'b1;
  assign xfer   = in_vld & in_rdy;
  // A start-of-frame byte is always header byte 0, whatever the state.
  assign wr_idx = in_sof ? 4'd0 : idx;
  // dst is complete by the time byte 13 arrives, so compare the stored field.
  assign dst_reject = P_FILTER_EN && (hdr_dst_mac != P_MAC_ADDR) &&
                      (hdr_dst_mac != 48'hFFFF_FFFF_FFFF);

  // Next-state and per-byte event decode.
  always_comb begin
    state_nxt = state;
    hdr_wr    = 1'b0;
    hdr_ok    = 1'b0;
    runt      = 1'b0;
    abort     = 1'b0;
    pl_load   = 1'b0;
    drop_inc  = 2'd0;
    if (xfer) begin
      if (in_sof) begin
        hdr_wr    = 1'b1;
        state_nxt = HDR;
        if (state == HDR || state == PAYLOAD) drop_inc = 2'd1;
        if (state == PAYLOAD) abort = 1'b1;
        if (in_eof) begin
          runt      = 1'b1;
          drop_inc  = drop_inc + 2'd1;
          state_nxt = IDLE;
        end
      end else begin
        case (state)
          HDR: begin
            hdr_wr = 1'b1;
            if (idx == 4'd13) begin
              if (dst_reject) begin
                drop_inc  = 2'd1;
                state_nxt = in_eof ? IDLE : DROP;
              end else begin
                hdr_ok    = 1'b1;
                state_nxt = in_eof ? IDLE : PAYLOAD;
              end
            end else if (in_eof) begin
              runt      = 1'b1;
              drop_inc  = 2'd1;
              state_nxt = IDLE;
            end
          end
          PAYLOAD: begin
            pl_load = 1'b1;
            if (in_eof) state_nxt = IDLE;
          end
          DROP: begin
            if (in_eof) state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  // State register and header byte index.
  always_ff @(posedge sys_rx_clk or posedge sys_rx_rst) begin
    if (sys_rx_rst) begin
      state <= IDLE;
      idx   <= 4'd0;
    end else begin
      state <= state_nxt;
      if (xfer && in_sof) idx <= 4'd1;
      else if (hdr_wr)    idx <= (idx == 4'd13) ? 4'd0 : idx + 4'd1;
    end
  end

  // Header fields: shift each byte into the field selected by its index.
  always_ff @(posedge sys_rx_clk or posedge sys_rx_rst) begin
    if (sys_rx_rst) begin
      hdr_dst_mac   <= 48'd0;
      hdr_src_mac   <= 48'd0;
      hdr_ethertype <= 16'd0;
    end else if (hdr_wr) begin
      if (wr_idx < 4'd6)       hdr_dst_mac   <= {hdr_dst_mac[39:0], in_byte};
      else if (wr_idx < 4'd12) hdr_src_mac   <= {hdr_src_mac[39:0], in_byte};
      else                     hdr_ethertype <= {hdr_ethertype[7:0], in_byte};
    end
  end

  // Payload output register; holds while stalled, drains when consumed.
  always_ff @(posedge sys_rx_clk or posedge sys_rx_rst) begin
    if (sys_rx_rst) begin
      pl_byte  <= 8'd0;
      pl_vld   <= 1'b0;
      pl_sof   <= 1'b0;
      pl_eof   <= 1'b0;
      pl_first <= 1'b0;
    end else begin
      if (pl_load) begin
        pl_byte <= in_byte;
        pl_vld  <= 1'b1;
        pl_sof  <= pl_first;
        pl_eof  <= in_eof;
      end else if (pl_rdy) begin
        pl_vld  <= 1'b0;
      end
      if (hdr_ok)       pl_first <= 1'b1;
      else if (pl_load) pl_first <= 1'b0;
    end
  end

  // Status pulses and saturating counters, all one cycle after the byte.
  always_ff @(posedge sys_rx_clk or posedge sys_rx_rst) begin
    if (sys_rx_rst) begin
      hdr_vld   <= 1'b0;
      runt_err  <= 1'b0;
      pl_abort  <= 1'b0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else begin
      hdr_vld   <= hdr_ok;
      runt_err  <= runt;
      pl_abort  <= abort;
      frame_cnt <= sat_add(frame_cnt, {1'b0, hdr_ok});
      drop_cnt  <= sat_add(drop_cnt, drop_inc);
    end
  end

endmodule

// File: tb/tb_eth_hdr_parser.sv
// Directed bench for eth_hdr_parser: table of whole frames plus hand-written
// backpressure, abort and mid-frame reset sequences.
module tb_eth_hdr_parser;

  localparam logic [47:0] MAC = 48'h3A52023E1800;
  localparam logic [47:0] SRC = 48'h021122334455;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_vld, in_rdy, in_sof, in_eof;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype;
  logic        hdr_vld;
  logic [7:0]  pl_byte;
  logic        pl_vld, pl_rdy, pl_sof, pl_eof, pl_abort, runt_err;
  logic [15:0] frame_cnt, drop_cnt;

  eth_hdr_parser #(.P_MAC_ADDR(MAC), .P_FILTER_EN(1'b1)) dut (
    .sys_rx_clk(clk), .sys_rx_rst(rst),
    .in_byte(in_byte), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_sof(in_sof), .in_eof(in_eof),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_vld(hdr_vld),
    .pl_byte(pl_byte), .pl_vld(pl_vld), .pl_rdy(pl_rdy),
    .pl_sof(pl_sof), .pl_eof(pl_eof), .pl_abort(pl_abort),
    .runt_err(runt_err), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  // Scoreboard and monitor state
  logic [9:0]  exp_q[$];
  logic [9:0]  e_item;
  logic [9:0]  prev_out;
  logic        stalled_prev = 1'b0;
  logic        chk_rdy = 1'b0;
  int          hdr_cnt = 0, runt_cnt = 0, abort_cnt = 0, pl_cnt = 0;
  logic [47:0] cap_dst, cap_src;
  logic [15:0] cap_type;

  // Monitor: samples on the falling edge, between active edges.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (hdr_vld) begin
        hdr_cnt++;
        cap_dst = hdr_dst_mac; cap_src = hdr_src_mac; cap_type = hdr_ethertype;
      end
      if (runt_err) runt_cnt++;
      if (pl_abort) abort_cnt++;
      if (stalled_prev) begin
        chk("hold_vld", pl_vld, 1);
        chk("hold_data", {pl_sof, pl_eof, pl_byte}, prev_out);
      end
      if (chk_rdy && pl_vld && !pl_rdy) chk("in_rdy_stall", in_rdy, 0);
      if (pl_vld && pl_rdy) begin
        pl_cnt++;
        if (exp_q.size() == 0) chk("pl_unexpected", {pl_sof, pl_eof, pl_byte}, 10'h3FF);
        else begin
          e_item = exp_q.pop_front();
          chk("pl_out", {pl_sof, pl_eof, pl_byte}, e_item);
        end
      end
      stalled_prev = pl_vld && !pl_rdy;
      prev_out = {pl_sof, pl_eof, pl_byte};
    end
  end

  // Downstream ready pattern 1,0,0,1 while backpressure mode is on.
  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_k = 0;
  initial forever begin
    @(posedge clk); #1;
    if (bp_mode) begin
      pl_rdy = bp_pat[bp_k % 4];
      bp_k++;
    end
  end

  task automatic put(input logic [7:0] b, input logic s, input logic e);
    in_byte = b; in_vld = 1'b1; in_sof = s; in_eof = e;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_rdy) begin
        @(posedge clk); #1;
        in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
        return;
      end
    end
    n_cmp++; n_err++;
    $display("FAIL put_timeout: byte %0h not accepted, required acceptance within 200 cycles", b);
    in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  // Header bytes then payload bytes 0,1,2,...; optionally queue expected payload.
  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int len, input bit push, input bit no_eof,
                            input bit gaps, input bit rdychk);
    logic [7:0] b;
    logic       last;
    for (int i = 0; i < len; i++) begin
      if (i < 6)        b = d[47-8*i -: 8];
      else if (i < 12)  b = s[47-8*(i-6) -: 8];
      else if (i == 12) b = t[15:8];
      else if (i == 13) b = t[7:0];
      else              b = 8'(i - 14);
      last = (i == len - 1) && !no_eof;
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
      end
      if (push && i >= 14) exp_q.push_back({(i == 14), last, b});
      chk_rdy = rdychk && (i >= 14) && (i < len - 1);
      put(b, (i == 0), last);
    end
    chk_rdy = 1'b0;
  endtask

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    int          len;
    bit          exp_hdr;
    bit          exp_runt;
    int          exp_drop;
  } vec_t;

  vec_t vt[9];
  int   exp_frame, exp_drop;
  int   h0, r0, a0, p0;

  initial begin
    vt[0] = '{MAC,             SRC,             16'h0800, 60, 1'b1, 1'b0, 0};
    vt[1] = '{48'h010203040506, SRC,            16'h0800, 60, 1'b0, 1'b0, 1};
    vt[2] = '{48'hFFFFFFFFFFFF, SRC,            16'h0806, 60, 1'b1, 1'b0, 0};
    vt[3] = '{MAC,             SRC,             16'h0800, 10, 1'b0, 1'b1, 1};
    vt[4] = '{MAC,             48'h665544332211, 16'h88B5, 14, 1'b1, 1'b0, 0};
    vt[5] = '{MAC,             SRC,             16'h1234, 15, 1'b1, 1'b0, 0};
    vt[6] = '{MAC,             SRC,             16'h0800,  1, 1'b0, 1'b1, 1};
    vt[7] = '{48'h010203040506, SRC,            16'h0800, 14, 1'b0, 1'b0, 1};
    vt[8] = '{MAC,             SRC,             16'h0800, 13, 1'b0, 1'b1, 1};

    rst = 1'b1; in_byte = 8'd0; in_vld = 1'b0; in_sof = 1'b0; in_eof = 1'b0; pl_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", in_rdy, 1);
    chk("rst_pl_vld", pl_vld, 0);
    chk("rst_hdr_vld", hdr_vld, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_dst", hdr_dst_mac, 0);
    rst = 1'b0;
    exp_frame = 0; exp_drop = 0;
    @(posedge clk); #1;

    // Table of whole frames
    for (int k = 0; k < 9; k++) begin
      h0 = hdr_cnt; r0 = runt_cnt; a0 = abort_cnt;
      send_frame(vt[k].dst, vt[k].src, vt[k].etype, vt[k].len, vt[k].exp_hdr, 1'b0, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      exp_frame += int'(vt[k].exp_hdr);
      exp_drop  += vt[k].exp_drop;
      chk($sformatf("v%0d_hdr_vld", k), hdr_cnt - h0, vt[k].exp_hdr);
      chk($sformatf("v%0d_runt", k), runt_cnt - r0, vt[k].exp_runt);
      chk($sformatf("v%0d_abort", k), abort_cnt - a0, 0);
      chk($sformatf("v%0d_frame_cnt", k), frame_cnt, exp_frame);
      chk($sformatf("v%0d_drop_cnt", k), drop_cnt, exp_drop);
      chk($sformatf("v%0d_pl_left", k), exp_q.size(), 0);
      if (vt[k].exp_hdr) begin
        chk($sformatf("v%0d_dst", k), cap_dst, vt[k].dst);
        chk($sformatf("v%0d_src", k), cap_src, vt[k].src);
        chk($sformatf("v%0d_type", k), cap_type, vt[k].etype);
      end
    end

    // Backpressure with random input gaps
    h0 = hdr_cnt; p0 = pl_cnt;
    bp_mode = 1'b1;
    send_frame(MAC, SRC, 16'h0806, 44, 1'b1, 1'b0, 1'b1, 1'b1);
    bp_mode = 1'b0; pl_rdy = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    exp_frame++;
    chk("bp_hdr_vld", hdr_cnt - h0, 1);
    chk("bp_pl_count", pl_cnt - p0, 30);
    chk("bp_pl_left", exp_q.size(), 0);
    chk("bp_frame_cnt", frame_cnt, exp_frame);

    // New in_sof after 20 payload bytes without eof
    h0 = hdr_cnt; a0 = abort_cnt;
    send_frame(MAC, SRC, 16'h0800, 34, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(MAC, 48'h0A0B0C0D0E0F, 16'h86DD, 18, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    exp_frame += 2; exp_drop++;
    chk("ab_abort", abort_cnt - a0, 1);
    chk("ab_hdr_vld", hdr_cnt - h0, 2);
    chk("ab_drop_cnt", drop_cnt, exp_drop);
    chk("ab_frame_cnt", frame_cnt, exp_frame);
    chk("ab_src", cap_src, 48'h0A0B0C0D0E0F);
    chk("ab_type", cap_type, 16'h86DD);
    chk("ab_pl_left", exp_q.size(), 0);

    // Reset during payload byte 5
    h0 = hdr_cnt; a0 = abort_cnt; r0 = runt_cnt;
    send_frame(MAC, SRC, 16'h0800, 19, 1'b1, 1'b1, 1'b0, 1'b0);
    in_byte = 8'h05; in_vld = 1'b1;
    @(negedge clk); #1;
    rst = 1'b1; in_vld = 1'b0;
    #1;
    chk("mr_pl_vld", pl_vld, 0);
    chk("mr_pl_flags", {pl_byte, pl_sof, pl_eof, pl_abort}, 0);
    chk("mr_hdr", {hdr_dst_mac, hdr_ethertype}, 0);
    chk("mr_src", hdr_src_mac, 0);
    chk("mr_cnts", {frame_cnt, drop_cnt}, 0);
    chk("mr_pulses", {hdr_vld, runt_err}, 0);
    chk("mr_in_rdy", in_rdy, 1);
    exp_frame = 0; exp_drop = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    p0 = pl_cnt;
    for (int i = 0; i < 10; i++) put(8'hA0 + 8'(i), 1'b0, (i == 9));
    repeat (3) @(posedge clk);
    #1;
    chk("mr_orphan_pl", pl_cnt - p0, 0);
    chk("mr_orphan_hdr", hdr_cnt - h0, 1);
    send_frame(MAC, SRC, 16'h0800, 17, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("mr_hdr_vld", hdr_cnt - h0, 2);
    chk("mr_frame_cnt", frame_cnt, 1);
    chk("mr_drop_cnt", drop_cnt, 0);
    chk("mr_abort", abort_cnt - a0, 0);
    chk("mr_runt", runt_cnt - r0, 0);
    chk("mr_pl_count", pl_cnt - p0, 3);
    chk("mr_pl_left", exp_q.size(), 0);
    chk("mr_dst", cap_dst, MAC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
